execute_stage_mc: RTL

Parametrised execute stage for the pipelined core. Generalises the fixed 16-bit execute cycle in three ways: data and register-address widths are configurable, branches support four compare modes, and an iterative multi-cycle multiplier stalls the front of the pipeline through a busy handshake. The block sits between the D/E pipeline register and the memory stage, and owns the E/M pipeline register.

---
 rtl/execute_stage_mc.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_mc.sv
// Parametrised execute stage: ALU, 4-mode branch compare, forwarding,
// iterative shift-add multiplier with busy handshake, and E/M register.
module execute_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  ALUSrcE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic [1:0]            BrFunctE,
  input  logic [3:0]            ALUControlE,
  input  logic                  FlushE,
  input  logic [DATA_W-1:0]     RD1_E,
  input  logic [DATA_W-1:0]     RD2_E,
  input  logic [DATA_W-1:0]     Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [DATA_W-1:0]     PCE,
  input  logic [DATA_W-1:0]     PCPlus4E,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  output logic                  BusyE,
  output logic                  PCSrcE,
  output logic [DATA_W-1:0]     PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_W-1:0]     PCPlus4M,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [DATA_W-1:0]     ALU_ResultM
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic                  regw_q, regw_d;
  logic                  memw_q, memw_d;
  logic                  ress_q, ress_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     pc4_q, pc4_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [DATA_W-1:0]     alu_q, alu_d;

  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_res;
  logic [SH_W-1:0]   shamt;
  logic              is_mul, br_eq, br_lt, br_cond;

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b  = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign shamt  = src_b[SH_W-1:0];
  assign is_mul = (ALUControlE == OP_MUL);

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                          $signed(src_a) < $signed(src_b)};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $signed(src_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses the register operand, never the immediate
  assign br_eq = (src_a == fwd_b);
  assign br_lt = $signed(src_a) < $signed(fwd_b);

  always_comb begin
    case (BrFunctE)
      2'b00:   br_cond = br_eq;
      2'b01:   br_cond = !br_eq;
      2'b10:   br_cond = br_lt;
      default: br_cond = !br_lt;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & br_cond);
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FlushE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (is_mul) state_d = S_BUSY;
        S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (!FlushE) begin
      if (state_q == S_IDLE && is_mul) begin
        mcand_d  = src_a;
        mplier_d = src_b;
        acc_d    = '0;
        cnt_d    = CNT_W'(DATA_W);
      end else if (state_q == S_BUSY) begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    BusyE  = !FlushE &&
             ((state_q == S_IDLE && is_mul) || state_q == S_BUSY);
    regw_d = 1'b0;
    memw_d = 1'b0;
    ress_d = 1'b0;
    rd_d   = '0;
    pc4_d  = '0;
    wd_d   = '0;
    alu_d  = '0;
    if (!FlushE &&
        ((state_q == S_IDLE && !is_mul) || state_q == S_DONE)) begin
      regw_d = RegWriteE;
      memw_d = MemWriteE;
      ress_d = ResultSrcE;
      rd_d   = RD_E;
      pc4_d  = PCPlus4E;
      wd_d   = fwd_b;
      alu_d  = (state_q == S_DONE) ? acc_q : alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      ress_q   <= 1'b0;
      rd_q     <= '0;
      pc4_q    <= '0;
      wd_q     <= '0;
      alu_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      ress_q   <= ress_d;
      rd_q     <= rd_d;
      pc4_q    <= pc4_d;
      wd_q     <= wd_d;
      alu_q    <= alu_d;
    end
  end

  assign RegWriteM   = regw_q;
  assign MemWriteM   = memw_q;
  assign ResultSrcM  = ress_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pc4_q;
  assign WriteDataM  = wd_q;
  assign ALU_ResultM = alu_q;

endmodule
